// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial ALU sequencer driving an external 1-bit ALU slice
module alu_serial_ctrl #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_ainv,
    output logic             slice_binv,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [2:0]       slice_op,
    input  logic             slice_cout,
    input  logic             slice_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NOR = 3'b110;

    localparam logic [2:0] SL_AND = 3'b000;
    localparam logic [2:0] SL_OR  = 3'b001;
    localparam logic [2:0] SL_ADD = 3'b010;
    localparam logic [2:0] SL_XOR = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_cflag;
    logic             r_vflag;

    logic w_accept;
    logic w_last;
    logic w_ovf;
    logic w_is_arith;
    logic w_done;

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_last     = (r_state == S_SHIFT) && (r_cnt == LAST_IDX);
    assign w_ovf      = r_carry ^ slice_cout;
    assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_done     = (r_state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_SHIFT;
            S_SHIFT: if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Slice drives are only live during SHIFT; the reserved op keeps them all at 0.
    always_comb begin
        in_ready   = (r_state == S_IDLE);
        out_valid  = w_done;
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_ainv = 1'b0;
        slice_binv = 1'b0;
        slice_cin  = 1'b0;
        slice_less = 1'b0;
        slice_op   = SL_AND;
        if (r_state == S_SHIFT && r_op != 3'b111) begin
            slice_a   = r_a[r_cnt];
            slice_b   = r_b[r_cnt];
            slice_cin = r_carry;
            case (r_op)
                OP_AND: slice_op = SL_AND;
                OP_OR:  slice_op = SL_OR;
                OP_ADD: slice_op = SL_ADD;
                OP_SUB: begin slice_binv = 1'b1; slice_op = SL_ADD; end
                OP_SLT: begin slice_binv = 1'b1; slice_op = SL_ADD; end
                OP_XOR: slice_op = SL_XOR;
                OP_NOR: begin slice_ainv = 1'b1; slice_binv = 1'b1; slice_op = SL_AND; end
                default: slice_op = SL_AND;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cflag  <= 1'b0;
            r_vflag  <= 1'b0;
        end else if (w_accept) begin
            r_op     <= op;
            r_a      <= a;
            r_b      <= b;
            r_cnt    <= '0;
            r_carry  <= (op == OP_SUB) || (op == OP_SLT);
            r_result <= '0;
            r_cflag  <= 1'b0;
            r_vflag  <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_carry <= slice_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (r_op != 3'b111) begin
                r_result[r_cnt] <= slice_result;
            end
            if (r_cnt == LAST_IDX) begin
                r_cflag <= w_is_arith & slice_cout;
                r_vflag <= w_is_arith & w_ovf;
                // SLT keeps only the sign of a-b corrected for overflow.
                if (r_op == OP_SLT) begin
                    r_result    <= '0;
                    r_result[0] <= slice_result ^ w_ovf;
                end
            end
        end
    end

    assign result   = r_result;
    assign zero     = w_done && (r_result == '0);
    assign carry    = r_cflag;
    assign overflow = r_vflag;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - directed self-checking bench for alu_serial_ctrl
module tb_alu_serial_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [23:0] a;
    logic [23:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] result;
    logic        zero, carry, overflow;
    logic        slice_a, slice_b, slice_ainv, slice_binv, slice_cin, slice_less;
    logic [2:0]  slice_op;
    logic        slice_cout, slice_result;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_serial_ctrl #(.WIDTH(24)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow),
        .slice_a(slice_a), .slice_b(slice_b), .slice_ainv(slice_ainv),
        .slice_binv(slice_binv), .slice_cin(slice_cin), .slice_less(slice_less),
        .slice_op(slice_op), .slice_cout(slice_cout), .slice_result(slice_result)
    );

    // Behavioural 1-bit ALU slice
    logic s_aa, s_bb;
    always_comb begin
        s_aa = slice_a ^ slice_ainv;
        s_bb = slice_b ^ slice_binv;
        slice_cout = (s_aa & s_bb) | (s_aa & slice_cin) | (s_bb & slice_cin);
        case (slice_op)
            3'b000:  slice_result = s_aa & s_bb;
            3'b001:  slice_result = s_aa | s_bb;
            3'b010:  slice_result = s_aa ^ s_bb ^ slice_cin;
            3'b011:  slice_result = slice_less;
            3'b100:  slice_result = s_aa ^ s_bb;
            default: slice_result = 1'b0;
        endcase
    end

    logic [10:0] slice_bus;
    assign slice_bus = {slice_a, slice_b, slice_ainv, slice_binv, slice_cin, slice_less, slice_op, 2'b00};

    // Drives one request from IDLE; releases the result only if out_ready is high.
    task automatic do_op(input logic [2:0] t_op, input logic [23:0] t_a, input logic [23:0] t_b,
                         output logic [23:0] r, output logic z, output logic c, output logic v,
                         output int lat, output int acc_cyc);
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0; a = ~t_a; b = t_b ^ 24'h5A5A5A; op = ~t_op;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result; z = zero; c = carry; v = overflow;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 3'b010; a = 24'h1; b = 24'h1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_handshake: got %b expected 10", {in_ready, out_valid});
        end
        n_tests++;
        if ({result, zero, carry, overflow} !== 27'd0) begin
            n_fail++; $display("FAIL reset_result: got %h/%b%b%b expected 0", result, zero, carry, overflow);
        end
        n_tests++;
        if (slice_bus !== 11'd0) begin
            n_fail++; $display("FAIL reset_slice: got %b expected 0", slice_bus);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_no_accept: in_ready %b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        logic [23:0] r; logic z, c, v; int lat, ac;
        do_op(3'b010, 24'h7FFFFF, 24'h000001, r, z, c, v, lat, ac);
        n_tests++;
        if ({r, z, c, v} !== {24'h800000, 3'b001}) begin
            n_fail++; $display("FAIL add_ovf: got %h z%b c%b v%b expected 800000 z0 c0 v1", r, z, c, v);
        end
        n_tests++;
        if (lat != 24) begin
            n_fail++; $display("FAIL add_latency: got %0d expected 24", lat);
        end
    endtask

    task automatic test_sub();
        logic [23:0] r; logic z, c, v; int lat, ac;
        do_op(3'b011, 24'h000005, 24'h000005, r, z, c, v, lat, ac);
        n_tests++;
        if ({r, z, c, v} !== {24'h000000, 3'b110}) begin
            n_fail++; $display("FAIL sub_zero: got %h z%b c%b v%b expected 000000 z1 c1 v0", r, z, c, v);
        end
    endtask

    task automatic test_slt();
        logic [23:0] va [3] = '{24'hFFFFFF, 24'h000001, 24'h800000};
        logic [23:0] vb [3] = '{24'h000001, 24'hFFFFFF, 24'h000001};
        logic [23:0] ve [3] = '{24'h000001, 24'h000000, 24'h000001};
        logic [23:0] r; logic z, c, v; int lat, ac;
        for (int i = 0; i < 3; i++) begin
            do_op(3'b100, va[i], vb[i], r, z, c, v, lat, ac);
            n_tests++;
            if ({r, z, c, v} !== {ve[i], (ve[i] == 24'd0), 2'b00}) begin
                n_fail++;
                $display("FAIL slt_%0d: got %h z%b c%b v%b expected %h", i, r, z, c, v, ve[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [2:0]  vo [4] = '{3'b110, 3'b101, 3'b000, 3'b001};
        logic [23:0] ve [4] = '{24'hF000F0, 24'h0FF00F, 24'h000F00, 24'h0FFF0F};
        logic [23:0] r; logic z, c, v; int lat, ac;
        for (int i = 0; i < 4; i++) begin
            do_op(vo[i], 24'h0F0F0F, 24'h00FF00, r, z, c, v, lat, ac);
            n_tests++;
            if ({r, z, c, v} !== {ve[i], 3'b000}) begin
                n_fail++;
                $display("FAIL logic_op%0d: got %h z%b c%b v%b expected %h z0 c0 v0", vo[i], r, z, c, v, ve[i]);
            end
        end
    endtask

    task automatic test_slice_drive();
        int n;
        op = 3'b011; a = 24'h000003; b = 24'h000001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; a = 24'h0; b = 24'h0;
        n_tests++;
        if ({slice_bus, in_ready} !== {11'b11_01_1_0_010_00, 1'b0}) begin
            n_fail++; $display("FAIL slice_sub_bit0: got %b expected 110110010000", {slice_bus, in_ready});
        end
        @(posedge clk); #1;
        n_tests++;
        if ({slice_a, slice_b, slice_cin} !== 3'b101) begin
            n_fail++; $display("FAIL slice_sub_bit1: got %b expected 101", {slice_a, slice_b, slice_cin});
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        n_tests++;
        if ({result, carry} !== {24'h000002, 1'b1}) begin
            n_fail++; $display("FAIL slice_sub_result: got %h c%b expected 000002 c1", result, carry);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reserved();
        logic [23:0] r; logic z, c, v; int lat, ac;
        op = 3'b111; a = 24'hFFFFFF; b = 24'hFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (slice_bus !== 11'd0) begin
            n_fail++; $display("FAIL reserved_slice: got %b expected 0", slice_bus);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if ({result, zero, carry, overflow, lat} !== {24'h0, 3'b100, 32'd19}) begin
            n_fail++; $display("FAIL reserved_result: got %h z%b c%b v%b lat %0d expected 0 z1 c0 v0 lat 19",
                               result, zero, carry, overflow, lat);
        end
        @(posedge clk); #1;
        r = '0; z = 0; c = 0; v = 0; ac = 0;
    endtask

    task automatic test_backpressure();
        logic [23:0] r; logic z, c, v; int lat, ac, bad;
        out_ready = 1'b0;
        do_op(3'b010, 24'h000001, 24'h000002, r, z, c, v, lat, ac);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid; a = $urandom; b = $urandom; op = 3'b010;
            @(posedge clk); #1;
            if ({out_valid, in_ready, result, zero, carry, overflow} !== {2'b10, 24'h000003, 3'b000}) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL hold_stable: %0d unstable cycles expected 0 (result %h)", bad, result);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL hold_release: got %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] r; logic z, c, v; int lat, ac1, ac2;
        do_op(3'b010, 24'hFFFFFF, 24'h000001, r, z, c, v, lat, ac1);
        n_tests++;
        if ({r, z, c, v} !== {24'h000000, 3'b110}) begin
            n_fail++; $display("FAIL b2b_add_wrap: got %h z%b c%b v%b expected 000000 z1 c1 v0", r, z, c, v);
        end
        do_op(3'b011, 24'h000000, 24'h000001, r, z, c, v, lat, ac2);
        n_tests++;
        if ({r, z, c, v} !== {24'hFFFFFF, 3'b000}) begin
            n_fail++; $display("FAIL b2b_sub_borrow: got %h z%b c%b v%b expected ffffff z0 c0 v0", r, z, c, v);
        end
        n_tests++;
        if (ac2 - ac1 != 26) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d expected 26", ac2 - ac1);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] r; logic z, c, v; int lat, ac;
        op = 3'b010; a = 24'h123456; b = 24'h654321; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, in_ready, result, zero, carry, overflow, slice_bus} !== {2'b01, 24'h0, 3'b000, 11'd0}) begin
            n_fail++; $display("FAIL mid_reset: ov%b ir%b res %h slice %b expected ov0 ir1 res 0 slice 0",
                               out_valid, in_ready, result, slice_bus);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_op(3'b010, 24'h123456, 24'h654321, r, z, c, v, lat, ac);
        n_tests++;
        if ({r, z, c, v, lat} !== {24'h777777, 3'b000, 32'd24}) begin
            n_fail++; $display("FAIL mid_reset_redo: got %h z%b c%b v%b lat %0d expected 777777 z0 c0 v0 lat 24",
                               r, z, c, v, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_slice_drive();
        test_reserved();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 24, operand/result width in bits; bit counter sized ceil(log2(WIDTH)).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request strobe.
REQ-005 in_ready  output  1  high when a request can be accepted.
REQ-006 op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 XOR, 110 NOR, 111 reserved.
REQ-007 a, b  input  WIDTH  operands, two's complement.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  WIDTH  operation result.
REQ-011 zero, carry, overflow  output  1 each  status flags.
REQ-012 slice_a, slice_b, slice_ainv, slice_binv, slice_cin, slice_less  output  1 each  drive to the 1-bit ALU slice.
REQ-013 slice_op  output  3  slice select: 000 AND, 001 OR, 010 ADD, 011 LESS, 100 XOR.
REQ-014 slice_cout, slice_result  input  1 each  combinational returns from the slice.

Function
REQ-015 FSM states: IDLE, SHIFT, DONE; reset state IDLE.
REQ-016 in_ready = 1 only in IDLE; handshake fires on in_valid && in_ready, which captures op, a and b, clears bit counter, and moves to SHIFT.
REQ-017 Operand changes after capture have no effect on the current operation.
REQ-018 SHIFT lasts exactly WIDTH cycles, bit index 0..WIDTH-1, LSB first; slice_a/slice_b = captured a/b at the current index.
REQ-019 Carry flop: loaded at accept with 1 for SUB/SLT, 0 otherwise; drives slice_cin; updated from slice_cout on every SHIFT edge.
REQ-020 Op mapping (ainv, binv, slice_op): AND (0,0,000); OR (0,0,001); ADD (0,0,010); SUB (0,1,010); SLT (0,1,010); XOR (0,0,100); NOR (1,1,000).
REQ-021 slice_less = 0 always; SLT is resolved inside this block.
REQ-022 Each SHIFT edge stores slice_result into result bit [index].
REQ-023 At index WIDTH-1: record cin_msb (carry-flop value) and cout_msb (slice_cout); overflow_int = cin_msb ^ cout_msb.
REQ-024 SLT: result = {WIDTH-1 zeros, sum_msb ^ overflow_int}; the subtraction sum is discarded.
REQ-025 Reserved op 111: same timing; all slice drives 0; result 0.
REQ-026 Flags (valid with out_valid): zero = (result == 0); carry = cout_msb for ADD/SUB, else 0; overflow = overflow_int for ADD/SUB, else 0.
REQ-027 After the last SHIFT edge, go to DONE; out_valid = 1 in DONE only; result and flags held stable while out_valid && !out_ready.
REQ-028 out_valid && out_ready moves to IDLE; in_ready rises the following cycle; no same-cycle accept in DONE.
REQ-029 Latency: out_valid rises WIDTH cycles after the accept edge; minimum request-to-request spacing WIDTH+2 cycles.
REQ-030 In IDLE and DONE, all slice_* outputs = 0.
REQ-031 in_valid is ignored outside IDLE.

Reset
REQ-032 reset asserted, including mid-SHIFT or in DONE, immediately forces IDLE and aborts the operation.
REQ-033 While reset is asserted: out_valid, result, flags, carry flop, counter and slice_* outputs = 0; in_ready = 1, but no accept occurs.
REQ-034 The first request after reset release completes with correct result and flags.

Verification
REQ-035 ADD a=0x7FFFFF, b=0x000001 -> result 0x800000, carry 0, overflow 1, zero 0; out_valid exactly 24 cycles after accept.
REQ-036 SUB a=0x000005, b=0x000005 -> result 0x000000, zero 1, carry 1, overflow 0.
REQ-037 SLT a=0xFFFFFF, b=0x000001 -> result 0x000001; SLT a=0x000001, b=0xFFFFFF -> result 0x000000; SLT a=0x800000, b=0x000001 -> result 0x000001 (overflow case).
REQ-038 NOR a=0x0F0F0F, b=0x00FF00 -> result 0xF000F0; XOR with the same operands -> result 0x0FF00F; carry and overflow 0.
REQ-039 Hold out_ready low for 10 cycles in DONE while toggling in_valid, a and b -> out_valid, result and flags stable, in_ready 0, no new accept; release out_ready -> in_ready 1 next cycle.
REQ-040 Assert reset at bit index 12 of ADD 0x123456 + 0x654321 -> all outputs 0 immediately; after release, the same ADD completes with result 0x777777.
